// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared types for the AXI-Lite write responder: the B channel
//               response codes, the write-path state encoding and a helper
//               that turns the decode/error outcome into a response code.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        RESP    = 2'd2
    } wr_state_t;

    // Decode miss wins over a register-side error: an unmapped address never
    // reaches the register bank, so its error input is meaningless there.
    function automatic axi_resp_t write_resp(input logic in_range, input logic werr);
        if (!in_range) begin
            return DECERR;
        end
        return werr ? SLVERR : OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_write_channel.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_write_channel
// Description : AXI-Lite write bus bundle (AW, W and B channels).
//   master modport : drives awvalid/awaddr/awprot, wvalid/wdata/wstrb, bready
//   slave  modport : drives awready, wready, bvalid, bresp
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_write_channel #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_hold_slot.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_hold_slot
// Description : One-entry holding register with a full flag.
//   clock, reset : clock and synchronous active-high reset
//   load         : capture din and mark full
//   clear        : mark empty (payload is kept, it is simply no longer valid)
//   din / dout   : payload in / held payload
//   full         : payload is valid
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_hold_slot #(
    parameter int WIDTH = 8
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full
);
    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // load and clear are never requested together by the write FSM; load is
    // given priority so a stray overlap can never lose a captured beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (load) begin
            r_data <= din;
            r_full <= 1'b1;
        end else if (clear) begin
            r_full <= 1'b0;
        end
    end

    assign dout = r_data;
    assign full = r_full;
endmodule
`default_nettype wire

// File: rtl/axi_lite_write_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_write_slave
// Description : AXI-Lite write responder. Collects AW and W independently (in
//               either order), performs one single-cycle register write and
//               returns the B response.
//   clock, reset        : clock and synchronous active-high reset
//   bus (slave modport) : AW / W / B channels
//   reg_wen             : one-cycle register write enable
//   reg_widx            : register index
//   reg_wdata/reg_wstrb : register write data and byte enables
//   reg_werr            : register-side error, sampled with reg_wen
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_write_slave
    import axi_lite_pkg::*;
#(
    parameter  int AXI_WDATA_WIDTH = 32,
    parameter  int AXI_ADDR_WIDTH  = 12,
    parameter  int NUM_REGS        = 16,
    localparam int C_STRB_W        = AXI_WDATA_WIDTH / 8,
    localparam int C_IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  wire logic                       clock,
    input  wire logic                       reset,
    axi_lite_write_channel.slave            bus,
    output logic                            reg_wen,
    output logic [C_IDX_W-1:0]              reg_widx,
    output logic [AXI_WDATA_WIDTH-1:0]      reg_wdata,
    output logic [C_STRB_W-1:0]             reg_wstrb,
    input  wire logic                       reg_werr
);
    localparam int C_ALIGN      = $clog2(C_STRB_W);
    localparam int C_FULL_IDX_W = AXI_ADDR_WIDTH - C_ALIGN;
    localparam int C_WPAY_W     = AXI_WDATA_WIDTH + C_STRB_W;

    wr_state_t                  r_state;
    wr_state_t                  w_state_next;
    axi_resp_t                  r_bresp;

    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_aw_full;
    logic                       w_w_full;
    logic                       w_in_write;
    logic                       w_write_en;
    logic                       w_idx_ok;
    logic [C_FULL_IDX_W-1:0]    w_idx;
    logic [C_WPAY_W-1:0]        w_wpayload;
    logic                       w_unused_ok;

    // Readies come only from registered state (plus reset), so there is no
    // combinational path from valid to ready.
    assign bus.awready = !w_aw_full && (r_state == COLLECT) && !reset;
    assign bus.wready  = !w_w_full  && (r_state == COLLECT) && !reset;
    assign w_aw_hs     = bus.awvalid && bus.awready;
    assign w_w_hs      = bus.wvalid  && bus.wready;
    assign w_in_write  = (r_state == WRITE);

    // Only the word index is kept; byte-offset bits carry no meaning here.
    axi_lite_hold_slot #(
        .WIDTH (C_FULL_IDX_W)
    ) u_aw_slot (
        .clock (clock),
        .reset (reset),
        .load  (w_aw_hs),
        .clear (w_in_write),
        .din   (bus.awaddr[AXI_ADDR_WIDTH-1:C_ALIGN]),
        .dout  (w_idx),
        .full  (w_aw_full)
    );

    axi_lite_hold_slot #(
        .WIDTH (C_WPAY_W)
    ) u_w_slot (
        .clock (clock),
        .reset (reset),
        .load  (w_w_hs),
        .clear (w_in_write),
        .din   ({bus.wdata, bus.wstrb}),
        .dout  (w_wpayload),
        .full  (w_w_full)
    );

    // Extra leading zero lets NUM_REGS == 2**C_FULL_IDX_W compare correctly.
    assign w_idx_ok = ({1'b0, w_idx} < (C_FULL_IDX_W + 1)'(NUM_REGS));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_write_en   = 1'b0;
        case (r_state)
            COLLECT: begin
                // A beat arriving this cycle counts as already held.
                if ((w_aw_full || w_aw_hs) && (w_w_full || w_w_hs)) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_write_en   = w_idx_ok;
                w_state_next = RESP;
            end
            RESP: begin
                if (bus.bready) begin
                    w_state_next = COLLECT;
                end
            end
            default: begin
                w_state_next = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bresp <= OKAY;
        end else if (w_in_write) begin
            r_bresp <= write_resp(w_idx_ok, reg_werr);
        end
    end

    assign bus.bvalid = (r_state == RESP) && !reset;
    assign bus.bresp  = r_bresp;

    assign reg_wen   = w_write_en && !reset;
    assign reg_widx  = w_idx[C_IDX_W-1:0];
    assign reg_wdata = w_wpayload[C_WPAY_W-1:C_STRB_W];
    assign reg_wstrb = w_wpayload[C_STRB_W-1:0];

    // awprot and the byte-offset address bits are deliberately ignored.
    assign w_unused_ok = ^{bus.awprot, bus.awaddr[C_ALIGN-1:0]};
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_write_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_write_slave
// Description : Self-checking bench for axi_lite_write_slave (32-bit data,
//               12-bit address, 16 registers). A transaction-level model
//               predicts the outputs every cycle; directed scenarios pin
//               latencies and response codes with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_write_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic        reg_wen;
    logic [3:0]  reg_widx;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_werr;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    axi_lite_write_channel #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    axi_lite_write_slave #(
        .AXI_WDATA_WIDTH (32),
        .AXI_ADDR_WIDTH  (12),
        .NUM_REGS        (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .reg_wen   (reg_wen),
        .reg_widx  (reg_widx),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_werr  (reg_werr)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // ---------------- event log filled by the compare process ---------------
    int          t_wen_cyc = -1, t_wen_idx = -1, n_wen = 0;
    logic [31:0] t_wen_data;
    logic [3:0]  t_wen_strb;
    int          t_b_first = -1, t_b_resp = -1, t_b_hs = -1, n_bhs = 0;
    bit          prev_bvalid = 1'b0;

    // ---------------- transaction-level model -------------------------------
    bit          m_aw_held = 0, m_w_held = 0, m_write_now = 0, m_b_pending = 0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_strb = '0;
    int          m_b_resp = 0;

    always @(negedge clock) begin
        bit e_awr, e_wr, e_wen, e_bv;
        e_awr = !reset && !m_aw_held && !m_write_now && !m_b_pending;
        e_wr  = !reset && !m_w_held  && !m_write_now && !m_b_pending;
        e_wen = !reset && m_write_now && (m_addr / 4 < 16);
        e_bv  = !reset && m_b_pending;

        check("awready", bus.awready, e_awr);
        check("wready",  bus.wready,  e_wr);
        check("reg_wen", reg_wen,     e_wen);
        check("bvalid",  bus.bvalid,  e_bv);
        if (e_wen) begin
            check("reg_widx",  reg_widx,  (m_addr / 4) % 16);
            check("reg_wdata", reg_wdata, m_data);
            check("reg_wstrb", reg_wstrb, m_strb);
        end
        if (e_bv) check("bresp", bus.bresp, m_b_resp);

        if (reg_wen) begin
            n_wen++;
            t_wen_cyc  = cyc;
            t_wen_idx  = reg_widx;
            t_wen_data = reg_wdata;
            t_wen_strb = reg_wstrb;
        end
        if (bus.bvalid && !prev_bvalid) begin
            t_b_first = cyc;
            t_b_resp  = bus.bresp;
        end
        if (bus.bvalid && bus.bready) begin
            n_bhs++;
            t_b_hs = cyc;
        end
        prev_bvalid = bus.bvalid;

        if (reset) begin
            m_aw_held = 0; m_w_held = 0; m_write_now = 0; m_b_pending = 0;
        end else if (m_write_now) begin
            m_write_now = 0;
            m_aw_held   = 0;
            m_w_held    = 0;
            m_b_pending = 1;
            m_b_resp    = (m_addr / 4 >= 16) ? 3 : (reg_werr ? 2 : 0);
        end else if (m_b_pending) begin
            if (bus.bready) m_b_pending = 0;
        end else begin
            if (bus.awvalid && e_awr) begin m_aw_held = 1; m_addr = int'(bus.awaddr); end
            if (bus.wvalid && e_wr)   begin m_w_held = 1; m_data = bus.wdata; m_strb = bus.wstrb; end
            if (m_aw_held && m_w_held) m_write_now = 1;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    int aw_hs_cyc, w_hs_cyc;

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic send_aw(input int dly, input logic [11:0] addr);
        bit ok = 0;
        repeat (dly) tick();
        bus.awaddr = addr; bus.awvalid = 1'b1; aw_hs_cyc = -1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (bus.awready) begin ok = 1; aw_hs_cyc = cyc; end
            tick();
        end
        bus.awvalid = 1'b0;
        if (!ok) check("aw_handshake_timeout", 0, 1);
    endtask

    task automatic send_w(input int dly, input logic [31:0] data, input logic [3:0] strb);
        bit ok = 0;
        repeat (dly) tick();
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; w_hs_cyc = -1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (bus.wready) begin ok = 1; w_hs_cyc = cyc; end
            tick();
        end
        bus.wvalid = 1'b0;
        if (!ok) check("w_handshake_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
        fork
            send_aw(aw_dly, addr);
            send_w(w_dly, data, strb);
        join
    endtask

    task automatic wait_b();
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clock);
            if (bus.bvalid && bus.bready) ok = 1;
            tick();
        end
        if (!ok) check("b_handshake_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ------------------------------------
    initial begin
        int r_cyc, n0, b0, hs;
        reset = 1'b1; reg_werr = 1'b0;
        bus.awvalid = 1'b1; bus.awaddr = 12'h004; bus.awprot = 3'b000;
        bus.wvalid = 1'b1; bus.wdata = 32'h1111_1111; bus.wstrb = 4'hF;
        bus.bready = 1'b1;

        // 1. reset held for three cycles with valids high
        tick();
        check("rst_awready", bus.awready, 0);
        check("rst_wready",  bus.wready,  0);
        check("rst_bvalid",  bus.bvalid,  0);
        check("rst_reg_wen", reg_wen,     0);
        check("rst_widx",    reg_widx,    0);
        check("rst_wdata",   reg_wdata,   0);
        check("rst_wstrb",   reg_wstrb,   0);
        check("rst_bresp",   bus.bresp,   0);
        tick(); tick();
        reset = 1'b0; r_cyc = cyc;
        do_write(12'h004, 32'h1111_1111, 4'hF, 0, 0);
        check("t1_first_aw", aw_hs_cyc, r_cyc);
        check("t1_first_w",  w_hs_cyc,  r_cyc);
        wait_b();
        check("t1_wen_idx", t_wen_idx, 1);

        // 2. aligned write
        do_write(12'h008, 32'hDEAD_BEEF, 4'hF, 0, 0);
        wait_b();
        check("t2_wen_cyc",  t_wen_cyc,  aw_hs_cyc + 1);
        check("t2_wen_idx",  t_wen_idx,  2);
        check("t2_wen_data", t_wen_data, 32'hDEAD_BEEF);
        check("t2_b_cyc",    t_b_first,  aw_hs_cyc + 2);
        check("t2_bresp",    t_b_resp,   0);

        // 3. W five cycles ahead of AW
        do_write(12'h01C, 32'hA5A5_5A5A, 4'b0101, 5, 0);
        wait_b();
        check("t3_aw_gap",   aw_hs_cyc - w_hs_cyc, 5);
        check("t3_wen_cyc",  t_wen_cyc,  aw_hs_cyc + 1);
        check("t3_wen_idx",  t_wen_idx,  7);
        check("t3_wen_strb", t_wen_strb, 4'b0101);
        check("t3_b_cyc",    t_b_first,  aw_hs_cyc + 2);

        // 4. out-of-range address
        n0 = n_wen;
        do_write(12'h040, 32'h0000_0001, 4'hF, 0, 0);
        wait_b();
        check("t4_no_wen", n_wen, n0);
        check("t4_b_cyc",  t_b_first, aw_hs_cyc + 2);
        check("t4_bresp",  t_b_resp, 3);

        // 5. B backpressure with a register-side error
        bus.bready = 1'b0; reg_werr = 1'b1;
        do_write(12'h00C, 32'hCAFE_F00D, 4'hF, 0, 0);
        hs = aw_hs_cyc;
        repeat (10) tick();
        check("t5_bvalid_held", bus.bvalid, 1);
        check("t5_bresp_held",  bus.bresp,  2);
        check("t5_b_cyc",       t_b_first,  hs + 2);
        reg_werr = 1'b0; bus.bready = 1'b1;
        do_write(12'h030, 32'h0F0F_0F0F, 4'hC, 0, 0);
        check("t5_next_aw", aw_hs_cyc, t_b_hs + 1);
        wait_b();
        check("t5_next_idx",  t_wen_idx, 12);
        check("t5_next_resp", t_b_resp,  0);

        // 6. reset while B is pending
        bus.bready = 1'b0;
        do_write(12'h010, 32'h0BAD_0BAD, 4'hF, 0, 0);
        tick();
        check("t6_bvalid_pre", bus.bvalid, 1);
        n0 = n_wen; b0 = n_bhs;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_bvalid_post", bus.bvalid, 0);
        bus.bready = 1'b1;
        repeat (5) tick();
        check("t6_no_reissue", n_bhs, b0);
        check("t6_no_wen",     n_wen, n0);
        do_write(12'h014, 32'h600D_F00D, 4'hF, 0, 0);
        wait_b();
        check("t6_new_wen_cyc", t_wen_cyc, aw_hs_cyc + 1);
        check("t6_new_idx",     t_wen_idx, 5);
        check("t6_new_bresp",   t_b_resp,  0);

        // 7. zero byte strobes still write
        do_write(12'h024, 32'h1234_5678, 4'h0, 0, 3);
        wait_b();
        check("t7_wen_cyc",  t_wen_cyc,  w_hs_cyc + 1);
        check("t7_wen_strb", t_wen_strb, 0);
        check("t7_wen_idx",  t_wen_idx,  9);
        check("t7_bresp",    t_b_resp,   0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
